pipe_stage_reg: RTL
===================

# pipe_stage_reg

Parametrised pipeline stage register: the successor to the fixed two-word IF/ID register. It carries `CHANNELS` independent words of `WIDTH` bits between two pipeline stages using a valid/ready handshake instead of a bare enable. It provides a synchronous flush, an optional two-entry skid buffer that registers the upstream ready, and a saturating stall-cycle counter. It is instantiated between any two stages of the MIPS pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB).

## Interface
- `WIDTH`, 32, bits per channel
- `CHANNELS`, 2, number of words carried per transfer
- `CNT_W`, 16, width of stall counter

- `clk` input 1: single clock, all state updates on rising edge
- `rst_n` input 1: asynchronous, active-low reset
- `flush` input 1: synchronous flush; drops all held entries
- `in_valid` input 1: upstream presents a transfer
- `in_ready` output 1: stage can accept this cycle
- `in_data` input `CHANNELS*WIDTH`: channel k at bits [k*WIDTH +: WIDTH]
- `out_valid` output 1: downstream transfer pending
- `out_ready` input 1: downstream accepts this cycle
- `out_data` output `CHANNELS*WIDTH`: same packing as `in_data`
- `stall_cnt` output `CNT_W`: cycles with `out_valid && !out_ready`

## Operation
- Accept = `in_valid && in_ready`; fire = `out_valid && out_ready`.
- Output register (`out_valid`, `out_data`); with skid enabled, a second skid register (`skid_valid`, `skid_data`).
- Output register update, applied when `!out_valid || out_ready`:
  - if `skid_valid`, load the skid contents and clear `skid_valid`;
  - else if accept, load `in_data` and set `out_valid`;
  - else clear `out_valid`.
- Skid update: on accept while `out_valid && !out_ready`, load `in_data` into skid and set `skid_valid`.
- `out_data` holds its last value while `out_valid`=0. It is never X after reset.
- Channels are opaque. No arithmetic, no reordering, no per-channel valid; all channels move together.
- Flush has priority over everything in the same cycle:
  - clears `out_valid` and `skid_valid`;
  - zeroes `out_data` and `skid_data`;
  - ignores any concurrent accept (data lost by design; upstream is flushed in the same cycle).
- `stall_cnt` increments by 1 each cycle `out_valid && !out_ready` is sampled high, saturates at 2^CNT_W-1, and is not cleared by flush.
- Reset values:
  - `out_valid`=0, `out_data`=0, `stall_cnt`=0;
  - `skid_valid`=0, `skid_data`=0;
  - `in_ready` is 1 one cycle after reset deasserts (skid mode), or immediately (no-skid mode).
- Reset asserted mid-transfer: all contents are lost, and the state immediately matches the reset values above.

## Timing
- Latency: an accept in cycle N gives `out_valid`=1 in cycle N+1 when the stage was empty.
- Throughput: one transfer per cycle while `out_ready`=1.
- Skid mode:
  - `in_ready` = `!skid_valid`, driven from a flop with no combinational path from `out_ready`;
  - after `out_ready` drops, the stage absorbs exactly one more word, then `in_ready`=0 from the next cycle;
  - after `out_ready` rises with the skid full, `in_ready` returns to 1 one cycle later, and the skid word appears on `out_data` in the cycle after the output fire.
- No-skid mode: `in_ready` = `!out_valid || out_ready`, combinational.
- Simultaneous fire and accept with an empty skid: `out_data` takes the new word next cycle, with no bubble.
- Flush in cycle N: `out_valid`=0 in N+1; `in_ready`=1 in N+1.

## Configuration
- Macro `PIPE_STAGE_SKID_EN`.
- Defined: the skid register is present and `in_ready` is registered, as above. Capacity is 2 entries.
- Undefined: no skid register, capacity 1, `in_ready` is combinational. All other behaviour is identical, including flush and `stall_cnt`.

## Test plan
- Reset then pass-through:
  - stimulus: `rst_n`=0 then released; send `in_data`={32'h11100000, 32'h00000999} with `out_ready`=1;
  - response: next cycle `out_valid`=1, `out_data`=same value, `stall_cnt`=0.
- Back-to-back stream:
  - stimulus: 8 consecutive words 1..8 with `out_ready`=1;
  - response: 8 consecutive output cycles, values 1..8, no bubble.
- Skid fill (SKID_EN):
  - stimulus: words A, B, C presented; `out_ready`=0 from the cycle A appears on the output;
  - response: B is absorbed, `in_ready`=0, C is held upstream; after `out_ready`=1, the output order is A, B, C;
  - counter: `stall_cnt` equals the number of stalled cycles.
- Flush with full stage:
  - stimulus: `flush`=1 for one cycle while holding {32'h12345678, 32'h87654321} and a concurrent `in_valid`;
  - response: next cycle `out_valid`=0, `out_data`=0, concurrent word not captured, `stall_cnt` unchanged.
- Counter saturation:
  - stimulus: `CNT_W`=4, `out_ready`=0 for 20 cycles with a valid output;
  - response: `stall_cnt`=15 and it holds.
- Async reset mid-stall:
  - stimulus: drop `rst_n` between clock edges with skid full;
  - response: `out_valid`, `skid_valid` and `stall_cnt` go to 0 immediately, without waiting for `clk`.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline stage carrying CHANNELS words of WIDTH bits, with flush and stall counter.
// Define PIPE_STAGE_SKID_EN for a two-entry stage whose in_ready comes straight from a flop.
module pipe_stage_reg #(
   parameter int WIDTH    = 32,
   parameter int CHANNELS = 2,
   parameter int CNT_W    = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      flush,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [CHANNELS*WIDTH-1:0] in_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [CHANNELS*WIDTH-1:0] out_data,
   output logic [CNT_W-1:0]          stall_cnt
);
   logic                      skid_valid;
   logic [CHANNELS*WIDTH-1:0] skid_data;
   logic                      accept;
   logic                      advance;
   assign accept  = in_valid && in_ready;
   assign advance = !out_valid || out_ready;
`ifdef PIPE_STAGE_SKID_EN
   logic ready_q;
   assign in_ready = ready_q;
   // ready_q tracks the next value of !skid_valid so in_ready never sees out_ready combinationally
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         skid_valid <= 1'b0;
         skid_data  <= '0;
         ready_q    <= 1'b0;
      end else if (flush) begin
         skid_valid <= 1'b0;
         skid_data  <= '0;
         ready_q    <= 1'b1;
      end else begin
         if (advance)
            skid_valid <= 1'b0;
         else if (accept) begin
            skid_valid <= 1'b1;
            skid_data  <= in_data;
         end
         ready_q <= advance || !(skid_valid || accept);
      end
`else
   assign skid_valid = 1'b0;
   assign skid_data  = '0;
   assign in_ready   = advance;
`endif
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (advance) begin
         out_valid <= skid_valid || accept;
         if (skid_valid || accept)
            out_data <= skid_valid ? skid_data : in_data;
      end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)
         stall_cnt <= '0;
      else if (out_valid && !out_ready && stall_cnt != {CNT_W{1'b1}})
         stall_cnt <= stall_cnt + CNT_W'(1);
endmodule
